// File: rtl/fetch_unit.sv
// fetch_unit: PC + direct-mapped I-cache fetch stage feeding the IF->ID queue through a one-entry hold register.
// Ports: clk/rst (sync, active-high), rdy freezes all state; clr/clr_pc redirect;
// IQ_full backpressure; IF_S/IF_Inst/IF_pc push strobe and payload;
// MC_req/MC_addr registered miss request; MC_done/MC_inst memory return.
module fetch_unit #(
  parameter int ICACHE_ENTRIES = 64,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic [31:0] clr_pc,
  input  logic        IQ_full,
  output logic        IF_S,
  output logic [31:0] IF_Inst,
  output logic [31:0] IF_pc,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_inst
);
  localparam int IW = $clog2(ICACHE_ENTRIES);
  localparam int TW = 30 - IW;
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
  state_t state;
  logic [31:0] pc, hold_inst, hold_pc;
  logic hold_v;
  logic [ICACHE_ENTRIES-1:0] line_v;
  logic [TW-1:0] tag_mem [ICACHE_ENTRIES];
  logic [31:0] inst_mem [ICACHE_ENTRIES];
  logic [IW-1:0] idx, fidx;
  logic hit, fill;
  assign idx = pc[IW+1:2];
  assign fidx = MC_addr[IW+1:2];
  assign hit = line_v[idx] && tag_mem[idx] == pc[31:IW+2];
  assign IF_S = hold_v & ~IQ_full & ~clr & rdy;
  assign IF_Inst = hold_inst;
  assign IF_pc = hold_pc;
  // The returned word always belongs to MC_addr, so it is filled even after a redirect.
  assign fill = rdy & MC_done & (state != FETCH);
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_mem[fidx] <= MC_addr[31:IW+2];
      inst_mem[fidx] <= MC_inst;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      hold_v <= 1'b0;
      hold_inst <= 32'h0;
      hold_pc <= 32'h0;
      MC_req <= 1'b0;
      MC_addr <= 32'h0;
      line_v <= '0;
    end else if (rdy) begin
      if (IF_S) hold_v <= 1'b0;
      if (fill) begin
        line_v[fidx] <= 1'b1;
        MC_req <= 1'b0;
        state <= FETCH;
      end
      if (clr) begin
        pc <= clr_pc;
        hold_v <= 1'b0;
        // An outstanding request must still complete; DRAIN discards nothing but the push.
        if (state == WAIT && !MC_done) state <= DRAIN;
      end else if (state == FETCH) begin
        if (!hit) begin
          MC_req <= 1'b1;
          MC_addr <= pc;
          state <= WAIT;
        end else if (!hold_v || IF_S) begin
          hold_v <= 1'b1;
          hold_inst <= inst_mem[idx];
          hold_pc <= pc;
          pc <= pc + 32'd4;
        end
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and the write side of the IF→ID instruction queue. It holds the program counter and looks up a direct-mapped instruction cache. On a miss it fetches the 32-bit word through the memory controller. Each fetched instruction/PC pair is pushed into the queue with a one-cycle strobe that the queue accepts unconditionally. On a redirect (`clr`) it restarts at the new PC.

## Interface
- `ICACHE_ENTRIES`, 64: number of direct-mapped lines, one instruction each. Power of two, ≥2.
- `RESET_PC`, 32'h0: PC loaded on reset.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global ready. When low, all state is frozen and `IF_S` is 0.
- `clr`  in  1  redirect or flush. Same-cycle as the queue's flush.
- `clr_pc`  in  32  redirect target, valid when `clr` is high.
- `IQ_full`  in  1  queue full, combinational from the queue's occupancy.
- `IF_S`  out  1  push strobe. The queue enqueues at the edge ending any cycle in which it is high.
- `IF_Inst`  out  32  instruction being pushed.
- `IF_pc`  out  32  PC of `IF_Inst`.
- `MC_req`  out  1  memory read request, registered, level.
- `MC_addr`  out  32  word address of the request, registered.
- `MC_done`  in  1  one-cycle pulse: `MC_inst` is valid.
- `MC_inst`  in  32  returned instruction word.

## Operation
- **Hold register.** `hold_v`, `hold_inst`, `hold_pc` form a one-entry skid buffer between the cache and the queue.
  - `IF_S = hold_v & ~IQ_full & ~clr & rdy`, combinational.
  - `IF_Inst = hold_inst` and `IF_pc = hold_pc`, combinational.
  - `hold_v` clears at the edge where `IF_S` is high, unless it is reloaded in the same edge.
- **Cache layout.** Index is `pc[log2(ICACHE_ENTRIES)+1:2]`. Tag is the remaining upper PC bits. Each line has a valid bit.
- **Cache read.** The read is combinational. hit = valid & tag match.
- **States.** FETCH, WAIT, DRAIN. Reset state is FETCH.
- **FETCH:**
  - If the lookup hits and the hold register is free (`~hold_v | IF_S`), load hold with {inst, pc} and set `pc <= pc+4`.
  - If the lookup hits but hold is busy, stall with pc unchanged.
  - If the lookup misses, set `MC_req <= 1` and `MC_addr <= pc`, then go to WAIT. This happens regardless of hold occupancy.
- **WAIT:**
  - `MC_req` and `MC_addr` stay stable.
  - On `MC_done`, write {valid, tag, `MC_inst`} to the line, set `MC_req <= 0`, and go to FETCH. The next cycle hits. The hold register is not loaded directly from memory.
- **DRAIN** (a redirect arrived while a request was outstanding):
  - `MC_req` stays held; the memory controller handshake is never abandoned.
  - On `MC_done`, fill the line (the data is correct for `MC_addr`), set `MC_req <= 0`, and go to FETCH.
- **clr, any state.**
  - `pc <= clr_pc` and `hold_v <= 0`. No hold load occurs in that cycle, and `IF_S` is 0.
  - From WAIT, go to DRAIN. From DRAIN, stay in DRAIN with pc updated again. From FETCH, stay in FETCH, and any miss request that would have issued is suppressed.
- **clr together with MC_done in WAIT or DRAIN.** Fill the line, set `MC_req <= 0`, go to FETCH with `pc = clr_pc`.
- **rdy low.** No state changes, no cache writes, `IF_S` = 0. An `MC_done` arriving while `rdy` is low is not a legal input; the memory controller is gated by the same `rdy`.
- **Reset priority.** `rst` dominates `clr` and `rdy`.
- **PC arithmetic.** 32-bit, wraps modulo 2^32. Bits [1:0] are carried through unchanged; alignment is not checked here.

## Timing
- **Reset values:** `pc = RESET_PC`, all line valid bits 0, `hold_v = 0`, `MC_req = 0`, `MC_addr = 0`, state FETCH. This gives `IF_S = 0`, `IF_Inst = 0`, `IF_pc = 0`.
- **Hit path.** Lookup in cycle N loads hold at edge N. `IF_S` can be high in cycle N+1.
- **Throughput.** Sustained hits with `IQ_full` low give one push per cycle.
- **Miss path.** Lookup in cycle N makes `MC_req` high from cycle N+1. If `MC_done` arrives in cycle M, `MC_req` is low from M+1, the line hits in M+1, and `IF_S` is high in M+2.
- **Backpressure.** Hold stays valid with contents stable while `IQ_full` is high. The push happens in the first cycle `IQ_full` is low. No instruction is lost or duplicated.
- **Memory handshake.** The memory controller samples `MC_req` and `MC_addr` at any edge while `MC_req` is high. It must not start a new access in the cycle that carries `MC_done`.

## Test plan
- **Cold start.** Reset with `RESET_PC=0`. Memory returns words 0x00000013, 0x00100093, … with 3-cycle latency. Required: pushes at PCs 0, 4, 8 with matching instructions; exactly one `MC_req` per PC; `IF_S` high exactly 2 cycles after each `MC_done`.
- **Warm loop.** Redirect with `clr`/`clr_pc` back to PC 0 after PCs 0–12 are cached. Required: 4 consecutive `IF_S` cycles for PCs 0, 4, 8, 12 and no `MC_req`.
- **Backpressure.** Hold `IQ_full` high for 5 cycles during warm hits. Required: `IF_S` low throughout, `IF_pc` stable; the next PC is pushed once, on the first cycle `IQ_full` is low.
- **Redirect mid-miss.** Assert `clr` with `clr_pc=0x100` while in WAIT for 0x40. Required: `MC_req` held until `MC_done`; line 0x40 filled but not pushed; next push is PC 0x100.
- **clr same cycle as MC_done.** Required: no push of the old word, `MC_req` low the next cycle, fetch restarts at `clr_pc`.
- **Alias eviction and rdy.** Use `ICACHE_ENTRIES=4`. PC 0x10 evicts PC 0x00, so PC 0x00 misses again. Toggle `rdy` low for 2 cycles mid-stream. Required: no state change and `IF_S=0` while `rdy` is low.
